divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits; opcode width `DIV_OP_WIDTH from riscv_defines.vh.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dividend_op  input  32  dividend (rs1).
REQ-005 divisor_op  input  32  divisor (rs2).
REQ-006 DIVop  input  `DIV_OP_WIDTH  operation select: `DIV_OP_DIV, `DIV_OP_DIVU, `DIV_OP_REM, `DIV_OP_REMU.
REQ-007 valid  input  1  request; held high by the core until ready is seen.
REQ-008 result  output  32  registered result; stable while ready is high.
REQ-009 ready  output  1  registered completion flag.

Function
REQ-010 States: IDLE, PREP, CALC, FIX, DONE; one-hot encoded; any illegal encoding goes to IDLE with ready=0.
REQ-011 IDLE: ready=0; on valid=1, capture dividend_op, divisor_op and DIVop into internal registers, go to PREP; operands are not re-sampled until the next return to IDLE.
REQ-012 Signedness: DIV and REM treat operands as two's complement; DIVU and REMU treat them as unsigned.
REQ-013 PREP: form the absolute values of the signed operands; record quotient sign (dividend sign XOR divisor sign, signed ops only) and remainder sign (dividend sign, signed ops only).
REQ-014 PREP, divisor==0: set quotient=0xFFFFFFFF and remainder=captured dividend, skip CALC, go to FIX.
REQ-015 PREP, DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: set quotient=0x80000000 and remainder=0, skip CALC, go to FIX.
REQ-016 PREP, otherwise: clear the partial remainder, load the magnitude dividend into the quotient shift register, load the bit counter with 31, go to CALC.
REQ-017 CALC is restoring division, one quotient bit per cycle:
- shift {rem, quo} left by 1;
- trial = rem - |divisor| (33-bit);
- if no borrow: rem = trial and quotient LSB = 1;
- leave CALC after exactly 32 cycles, going to FIX.
REQ-018 FIX: write result = quotient (DIV/DIVU) or remainder (REM/REMU), each negated when its recorded sign is set (special-case values of REQ-014/015 are written unmodified); go to DONE.
REQ-019 DONE: ready<=1 while valid=1; if valid=0 in DONE, ready<=0 and go to IDLE (this deassertion takes priority).
REQ-020 Latency, with E0 the accepting edge:
- normal ops: ready rises at edge E0+35;
- special cases: ready rises at edge E0+3.
REQ-021 ready deasserts on the edge after valid falls; a new request can be accepted no earlier than the edge after that.
REQ-022 Deasserting valid during PREP, CALC or FIX does not abort the operation; the operation completes and result is updated.

Reset
REQ-023 While reset=1 at a clock edge: state=IDLE, ready=0, result=0, and all internal registers are cleared.
REQ-024 Reset mid-operation abandons the computation; no ready pulse occurs afterwards.

Structure
REQ-025 The `DIV_OP_* encodings and `DIV_OP_WIDTH are defined in the shared riscv_defines.vh header, alongside the `MUL_OP_* encodings; none are defined locally.
REQ-026 Single module with no sub-module; absolute-value and negate logic is inline combinational.
REQ-027 The datapath uses one 33-bit subtractor only; a DSP or hard divider is not used.

Verification
REQ-028 DIVU 100/7 -> result 14 at E0+35; REMU 100/7 -> result 2.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; ready at E0+3 in both cases.
REQ-031 Divide by zero, ready at E0+3 in every case:
- DIVU 5/0 -> 0xFFFFFFFF;
- REMU 5/0 -> 5;
- DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF;
- REM 0xFFFFFFFB/0 -> 0xFFFFFFFB.
REQ-032 Reset pulsed during the 10th CALC cycle -> ready=0 and result=0 on the following edge; a next request DIVU 9/3 returns 3.
REQ-033 Back-to-back handshake:
- hold valid -> ready stays high;
- drop valid -> ready low on the next edge;
- raise valid with new operands -> accepted, and the new result is correct.

Source files
------------

// File: rtl/divider_pkg.sv
// Types, constants and operation-decode helpers for the iterative divider.
`include "riscv_defines.vh"

package divider_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = `DIV_OP_WIDTH;

    localparam logic [OP_W-1:0] OP_DIV  = `DIV_OP_DIV;
    localparam logic [OP_W-1:0] OP_DIVU = `DIV_OP_DIVU;
    localparam logic [OP_W-1:0] OP_REM  = `DIV_OP_REM;
    localparam logic [OP_W-1:0] OP_REMU = `DIV_OP_REMU;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_PREP = 5'b00010,
        ST_CALC = 5'b00100,
        ST_FIX  = 5'b01000,
        ST_DONE = 5'b10000
    } state_e;

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
        return (en && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/riscv_defines.vh
// Shared RISC-V core encodings for the M-extension multiply and divide units.
`ifndef RISCV_DEFINES_VH
`define RISCV_DEFINES_VH

`define MUL_OP_WIDTH 2
`define MUL_OP_MUL    2'b00
`define MUL_OP_MULH   2'b01
`define MUL_OP_MULHSU 2'b10
`define MUL_OP_MULHU  2'b11

`define DIV_OP_WIDTH 2
`define DIV_OP_DIV  2'b00
`define DIV_OP_DIVU 2'b01
`define DIV_OP_REM  2'b10
`define DIV_OP_REMU 2'b11

`endif

// File: rtl/divider.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU: one quotient bit
// per cycle through a single 33-bit subtractor, with a valid/ready handshake.
module divider
    import divider_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] dividend_op,
    input  logic [XLEN-1:0] divisor_op,
    input  logic [OP_W-1:0] DIVop,
    input  logic            valid,
    output logic [XLEN-1:0] result,
    output logic            ready
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, ready_d;

    logic              signed_op;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              no_borrow;

    assign signed_op = op_is_signed(op_q);

    // The remainder stays below the divisor, so a set top bit after the shift
    // already guarantees the subtraction cannot borrow.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign trial     = shifted - {1'b0, divisor_q};
    assign no_borrow = shifted[XLEN] | ~trial[XLEN];

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op_d       = op_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    dividend_d = dividend_op;
                    divisor_d  = divisor_op;
                    op_d       = DIVop;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                if (divisor_q == '0) begin
                    quo_d     = '1;
                    rem_d     = dividend_q;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    state_d   = ST_FIX;
                end else if (signed_op && dividend_q == INT_MIN && divisor_q == '1) begin
                    quo_d     = INT_MIN;
                    rem_d     = '0;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    state_d   = ST_FIX;
                end else begin
                    rem_d     = '0;
                    quo_d     = abs_if(dividend_q, signed_op);
                    divisor_d = abs_if(divisor_q, signed_op);
                    quo_neg_d = signed_op & (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]);
                    rem_neg_d = signed_op & dividend_q[XLEN-1];
                    cnt_d     = 5'd31;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                quo_d = {quo_q[XLEN-2:0], no_borrow};
                rem_d = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIX: begin
                if (op_is_rem(op_q)) begin
                    result_d = rem_neg_q ? -rem_q : rem_q;
                end else begin
                    result_d = quo_neg_q ? -quo_q : quo_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is only ever written with non-blocking assignments here, so
    // every flop samples the settled _d values of the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            op_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver queues expected results and ready
// edges, and an independent monitor checks each rising ready against them.
module tb_divider;
    import divider_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [31:0]     dividend_op;
    logic [31:0]     divisor_op;
    logic [OP_W-1:0] div_op;
    logic            valid;
    logic [31:0]     result;
    logic            ready;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic ready_seen = 1'b0;

    divider dut (
        .clk         (clk),
        .reset       (reset),
        .dividend_op (dividend_op),
        .divisor_op  (divisor_op),
        .DIVop       (div_op),
        .valid       (valid),
        .result      (result),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every rising ready must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ready === 1'b1 && !ready_seen) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.res);
                check({mon_e.name, "_ready_edge"}, 32'(cyc), 32'(mon_e.due));
            end
        end
        ready_seen = (ready === 1'b1);
    end

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_op(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int lat, input int hold,
                          input string name);
        exp_t e;
        bit   seen;
        seen        = 1'b0;
        dividend_op = a;
        divisor_op  = b;
        div_op      = op;
        valid       = 1'b1;
        e.res  = exp_res;
        e.due  = cyc + 1 + lat;
        e.name = name;
        sb_q.push_back(e);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = (ready === 1'b1);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: ready still low after 60 cycles, required 1", name);
            e     = sb_q.pop_back();
            valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_ready"}, 32'(ready), 32'd1);
            check({name, "_hold_result"}, result, exp_res);
        end
        valid = 1'b0;
        @(negedge clk);
        check({name, "_ready_drop"}, 32'(ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        valid       = 1'b0;
        dividend_op = '0;
        divisor_op  = '0;
        div_op      = OP_DIVU;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 0, "divu_100_7");
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 35, 0, "remu_100_7");
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 0, "div_m7_2");
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 0, "rem_m7_2");
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0, "div_7_m2");
        run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 35, 0, "rem_7_m2");

        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 0, "div_ovf");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3, 0, "rem_ovf");
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 3, 0, "divu_by0");
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 3, 0, "remu_by0");
        run_op(OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 3, 0, "div_by0");
        run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 3, 0, "rem_by0");

        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, 0, "divu_max_1");
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 35, 0, "remu_max_min");
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, 0, "divu_min_max");
        run_op(OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 35, 0, "div_min_2");
        run_op(OP_REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 35, 0, "rem_min_3");

        // Back-to-back: hold valid past ready, then a new request right after the drop.
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 35, 3, "b2b_first");
        run_op(OP_REMU, 32'd1000, 32'd7, 32'd6, 35, 0, "b2b_second");

        // Valid dropped mid-operation: result still lands, but no ready pulse.
        dividend_op = 32'd1000;
        divisor_op  = 32'd10;
        div_op      = OP_DIVU;
        valid       = 1'b1;
        repeat (5) @(negedge clk);
        valid = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_valid_result", result, 32'd100);
        check("abort_valid_ready", 32'(ready), 32'd0);

        // Reset sampled at the edge ending the 10th CALC cycle.
        dividend_op = 32'd1000;
        divisor_op  = 32'd3;
        div_op      = OP_DIVU;
        valid       = 1'b1;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_result", result, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("postreset_ready", 32'(ready), 32'd0);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 35, 0, "divu_9_3");

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
